// File: rtl/opb_register_simulink2ppc_capture_if.sv
// OPB slave-side signal bundle for the simulink2ppc capture register.
// Big-endian bit numbering as on the OPB: bit 0 is the MSB of every bus.
interface opb_register_simulink2ppc_capture_if;

    // Handshake: the master raises OPB_select with address, RNW, BE and write data
    // stable and holds them until it sees Sl_xferAck; the slave pulses Sl_xferAck
    // for exactly one cycle and drives Sl_DBus only during that cycle (zero otherwise,
    // so several slaves can be OR-ed onto one read bus). The master then drops
    // OPB_select before starting its next transfer.
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;

    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

endinterface

// File: rtl/opb_register_simulink2ppc_capture.sv
// Fabric-to-PPC capture register on the OPB: DATA/STATUS/CTRL/TSTAMP with new/overrun flags.
// Optional capture timestamp is enabled by defining CAPTURE_TIMESTAMP_EN.
module opb_register_simulink2ppc_capture #(
    parameter logic [31:0] C_BASEADDR   = 32'h01004100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010041FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6",
    parameter int          C_CNT_WIDTH  = 16
) (
    input  logic                                  OPB_Clk,
    input  logic                                  OPB_Rst_n,
    opb_register_simulink2ppc_capture_if.slave    opb,
    input  logic [31:0]                           user_data_in,
    input  logic                                  user_data_valid,
    output logic                                  user_frozen,
    output logic [1:0]                            dbg_state
);

    // Elaboration-time sanity of the EDK parameter set.
    if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32 ||
        C_HIGHADDR != C_BASEADDR + 32'h000000FF ||
        C_CNT_WIDTH < 1 || C_CNT_WIDTH > 16 || $bits(C_FAMILY) == 0) begin : g_bad_cfg
        $error("opb_register_simulink2ppc_capture: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } opb_state_t;

    localparam logic [1:0] W_DATA   = 2'd0;
    localparam logic [1:0] W_STATUS = 2'd1;
    localparam logic [1:0] W_CTRL   = 2'd2;
    localparam logic [1:0] W_TSTAMP = 2'd3;

    opb_state_t             state_q;
    logic [31:0]            sl_dbus_q;
    logic                   sl_xferack_q;
    logic                   acc_data_rd_q;
    logic                   acc_ctrl_wr_q;
    logic [1:0]             acc_ctrl_wdata_q;

    logic [31:0]            data_q;
    logic                   new_q;
    logic                   overrun_q;
    logic                   freeze_q;
    logic [C_CNT_WIDTH-1:0] count_q;

    logic                   addr_hit;
    logic [1:0]             word_sel;
    logic [31:0]            status_word;
    logic [31:0]            tstamp_word;
    logic [31:0]            rd_mux;
    logic                   capture;
    logic                   data_rd_clr;
    logic                   ctrl_wr;
    logic                   unused_opb;

    assign addr_hit = (opb.OPB_ABus[0:23] == C_BASEADDR[31:8]);
    assign word_sel = opb.OPB_ABus[28:29];

    assign status_word = {16'(count_q), 14'd0, overrun_q, new_q};

    always_comb begin
        rd_mux = 32'd0;
        case (word_sel)
            W_DATA:   rd_mux = data_q;
            W_STATUS: rd_mux = status_word;
            W_CTRL:   rd_mux = {31'd0, freeze_q};
            W_TSTAMP: rd_mux = tstamp_word;
            default:  rd_mux = 32'd0;
        endcase
    end

    // Transfer FSM. Read data and the side effects of the access are decided on
    // the IDLE->ACK edge so the ACK cycle works from registered state only.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q          <= ST_IDLE;
            sl_dbus_q        <= 32'd0;
            sl_xferack_q     <= 1'b0;
            acc_data_rd_q    <= 1'b0;
            acc_ctrl_wr_q    <= 1'b0;
            acc_ctrl_wdata_q <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sl_dbus_q    <= 32'd0;
                    sl_xferack_q <= 1'b0;
                    if (opb.OPB_select && addr_hit) begin
                        state_q          <= ST_ACK;
                        sl_xferack_q     <= 1'b1;
                        sl_dbus_q        <= opb.OPB_RNW ? rd_mux : 32'd0;
                        acc_data_rd_q    <= opb.OPB_RNW && (word_sel == W_DATA);
                        acc_ctrl_wr_q    <= !opb.OPB_RNW && (word_sel == W_CTRL) && opb.OPB_BE[3];
                        acc_ctrl_wdata_q <= opb.OPB_DBus[30:31];
                    end
                end
                ST_ACK: begin
                    state_q      <= ST_WAIT;
                    sl_dbus_q    <= 32'd0;
                    sl_xferack_q <= 1'b0;
                end
                ST_WAIT: begin
                    sl_dbus_q    <= 32'd0;
                    sl_xferack_q <= 1'b0;
                    if (!opb.OPB_select) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    sl_dbus_q    <= 32'd0;
                    sl_xferack_q <= 1'b0;
                end
            endcase
        end
    end

    assign capture     = user_data_valid && !freeze_q;
    assign data_rd_clr = (state_q == ST_ACK) && acc_data_rd_q;
    assign ctrl_wr     = (state_q == ST_ACK) && acc_ctrl_wr_q;

    // A capture landing on the DATA-read ack edge wins: the new value is flagged
    // as fresh and the overrun it would otherwise cause is discarded with the read.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            data_q    <= 32'd0;
            new_q     <= 1'b0;
            overrun_q <= 1'b0;
            freeze_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            if (capture) begin
                data_q <= user_data_in;
            end

            if (capture) begin
                new_q <= 1'b1;
            end else if (data_rd_clr) begin
                new_q <= 1'b0;
            end

            if (data_rd_clr) begin
                overrun_q <= 1'b0;
            end else if (capture && new_q) begin
                overrun_q <= 1'b1;
            end

            if (ctrl_wr && acc_ctrl_wdata_q[1]) begin
                count_q <= capture ? C_CNT_WIDTH'(1) : '0;
            end else if (capture) begin
                count_q <= count_q + 1'b1;
            end

            if (ctrl_wr) begin
                freeze_q <= acc_ctrl_wdata_q[0];
            end
        end
    end

`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] tstamp_q;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            cycle_cnt_q <= 32'd0;
            tstamp_q    <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (capture) begin
                tstamp_q <= cycle_cnt_q;
            end
        end
    end

    assign tstamp_word = tstamp_q;
`else
    assign tstamp_word = 32'd0;
`endif

    assign opb.Sl_DBus    = sl_dbus_q;
    assign opb.Sl_xferAck = sl_xferack_q;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    assign user_frozen = freeze_q;
    assign dbg_state   = state_q;

    // Single-beat, word-granular slave: these bus bits carry nothing for it.
    assign unused_opb = ^{opb.OPB_seqAddr, opb.OPB_ABus[24:27], opb.OPB_ABus[30:31],
                          opb.OPB_BE[0:2], opb.OPB_DBus[0:29]};

endmodule

// File: tb/tb_opb_register_simulink2ppc_capture.sv
// Directed scoreboard bench for opb_register_simulink2ppc_capture (default build).
module tb_opb_register_simulink2ppc_capture;

  localparam logic [31:0] BASE = 32'h01004100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] user_data_in = 32'd0;
  logic        user_data_valid = 1'b0;
  logic        user_frozen;
  logic [1:0]  dbg_state;

  opb_register_simulink2ppc_capture_if bus();

  opb_register_simulink2ppc_capture dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .opb             (bus),
    .user_data_in    (user_data_in),
    .user_data_valid (user_data_valid),
    .user_frozen     (user_frozen),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_fail = 0;
  int          ack_count = 0;
  logic        prev_ack = 1'b0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      check("tieoffs", {29'd0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);
      if (bus.Sl_xferAck) begin
        ack_count++;
        check("ack_single_cycle", {31'd0, prev_ack}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          check(name_q.pop_front(), bus.Sl_DBus, exp_q.pop_front());
        end
      end else begin
        check("dbus_idle_zero", bus.Sl_DBus, 32'd0);
      end
    end
    prev_ack = bus.Sl_xferAck;
  end

  // driver tasks
  task automatic opb_xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, input bit cap_en,
                          input logic [31:0] cap_data, input bit exp_ack,
                          input logic [31:0] exp_data, input string nm);
    int acks0;
    bit got;
    if (exp_ack) begin
      exp_q.push_back(exp_data);
      name_q.push_back(nm);
    end
    @(posedge clk); #1;
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = rnw;
    bus.OPB_DBus   = wdata;
    bus.OPB_BE     = be;
    bus.OPB_select = 1'b1;
    acks0 = ack_count;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk); #1;
      if (ack_count != acks0) got = 1'b1;
    end
    if (got && cap_en) begin
      user_data_in    = cap_data;
      user_data_valid = 1'b1;
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    user_data_valid = 1'b0;
    bus.OPB_select  = 1'b0;
    bus.OPB_RNW     = 1'b1;
    bus.OPB_DBus    = 32'd0;
    if (exp_ack && !got) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    repeat (2) @(negedge clk); #1;
    check({nm, "_acks"}, 32'(ack_count - acks0), exp_ack ? 32'd1 : 32'd0);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string nm);
    opb_xfer(BASE + 32'(off), 1'b1, 32'd0, 4'hF, 0, 1'b0, 32'd0, 1'b1, exp, nm);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] be,
                    input string nm);
    opb_xfer(BASE + 32'(off), 1'b0, data, be, 0, 1'b0, 32'd0, 1'b1, 32'd0, nm);
  endtask

  task automatic pulse(input logic [31:0] d);
    @(posedge clk); #1;
    user_data_in    = d;
    user_data_valid = 1'b1;
    @(posedge clk); #1;
    user_data_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.OPB_ABus    = 32'd0;
    bus.OPB_BE      = 4'h0;
    bus.OPB_DBus    = 32'd0;
    bus.OPB_RNW     = 1'b1;
    bus.OPB_select  = 1'b0;
    bus.OPB_seqAddr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_frozen", {31'd0, user_frozen}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    rd(8'h00, 32'h0000_0000, "rst_data");
    rd(8'h04, 32'h0000_0000, "rst_status");
    rd(8'h08, 32'h0000_0000, "rst_ctrl");

    pulse(32'hDEAD_BEEF);
    rd(8'h04, 32'h0001_0001, "cap1_status");
    rd(8'h00, 32'hDEAD_BEEF, "cap1_data");
    rd(8'h04, 32'h0001_0000, "cap1_status_clr");

    wr(8'h08, 32'h0000_0002, 4'hF, "clr_cnt_a");
    rd(8'h08, 32'h0000_0000, "ctrl_clr_reads0");
    pulse(32'h0000_0001);
    pulse(32'h0000_0002);
    rd(8'h04, 32'h0002_0003, "ovr_status");
    rd(8'h00, 32'h0000_0002, "ovr_data");
    rd(8'h04, 32'h0002_0000, "ovr_status_clr");

    wr(8'h08, 32'h0000_0001, 4'hF, "freeze_on");
    check("frozen_on", {31'd0, user_frozen}, 32'd1);
    rd(8'h08, 32'h0000_0001, "ctrl_freeze");
    pulse(32'h0000_0055);
    rd(8'h04, 32'h0002_0000, "frz_status");
    rd(8'h00, 32'h0000_0002, "frz_data");
    wr(8'h08, 32'h0000_0002, 4'hF, "clr_unfreeze");
    rd(8'h04, 32'h0000_0000, "clr_status");
    check("frozen_off", {31'd0, user_frozen}, 32'd0);
    rd(8'h08, 32'h0000_0000, "ctrl_after_clr");

    wr(8'h08, 32'h0000_0001, 4'b1110, "ctrl_be_off");
    rd(8'h08, 32'h0000_0000, "ctrl_be_ignored");
    check("frozen_be_off", {31'd0, user_frozen}, 32'd0);

    wr(8'h00, 32'hFFFF_FFFF, 4'hF, "ro_data_wr");
    rd(8'h00, 32'h0000_0002, "ro_data_kept");
    wr(8'h04, 32'hFFFF_FFFF, 4'hF, "ro_status_wr");
    rd(8'h04, 32'h0000_0000, "ro_status_kept");

    pulse(32'h0000_0077);
    opb_xfer(BASE, 1'b1, 32'd0, 4'hF, 0, 1'b1, 32'h0000_0099, 1'b1, 32'h0000_0077, "race_data");
    rd(8'h04, 32'h0002_0001, "race_status");
    rd(8'h00, 32'h0000_0099, "race_new_data");

    opb_xfer(BASE + 32'h4, 1'b1, 32'd0, 4'hF, 3, 1'b0, 32'd0, 1'b1, 32'h0002_0000, "hold3");

    opb_xfer(32'h0100_4200, 1'b1, 32'd0, 4'hF, 0, 1'b0, 32'd0, 1'b0, 32'd0, "miss_rd");
    opb_xfer(32'h0100_4208, 1'b0, 32'h1, 4'hF, 0, 1'b0, 32'd0, 1'b0, 32'd0, "miss_wr");
    rd(8'h08, 32'h0000_0000, "miss_ctrl_kept");

    opb_xfer(BASE + 32'h8, 1'b0, 32'h2, 4'hF, 0, 1'b1, 32'h0000_00AB, 1'b1, 32'd0, "clr_cap");
    rd(8'h04, 32'h0001_0001, "clr_cap_status");
    rd(8'h00, 32'h0000_00AB, "clr_cap_data");

`ifndef CAPTURE_TIMESTAMP_EN
    rd(8'h0C, 32'h0000_0000, "tstamp_off");
`endif

    wr(8'h08, 32'h0000_0001, 4'hF, "freeze_pre_rst");
    @(posedge clk); #1;
    bus.OPB_ABus   = BASE + 32'h4;
    bus.OPB_RNW    = 1'b1;
    bus.OPB_select = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    begin
      int acks0;
      acks0 = ack_count;
      repeat (2) @(posedge clk); #1;
      bus.OPB_select = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk); #1;
      check("midrst_no_ack", 32'(ack_count - acks0), 32'd0);
    end
    check("midrst_frozen", {31'd0, user_frozen}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    rd(8'h04, 32'h0000_0000, "midrst_status");
    rd(8'h00, 32'h0000_0000, "midrst_data");
    rd(8'h08, 32'h0000_0000, "midrst_ctrl");

    repeat (4) @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
